// File: rtl/rf_issue_scoreboard.sv
// Register-file issue scoreboard for a 2-wide in-order pipeline: tracks busy
// destinations, gates dual/single issue on RAW/WAW hazards and drains on flush.
module rf_issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int RS    = 5,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           i_slot_valid,
    input  logic [1:0][RS-1:0]   i_slot_rs1,
    input  logic [1:0][RS-1:0]   i_slot_rs2,
    input  logic [1:0][RS-1:0]   i_slot_rd,
    input  logic [1:0]           i_slot_we,
    input  logic                 i_issue_ready,
    input  logic [1:0]           i_wb_valid,
    input  logic [1:0][RS-1:0]   i_wb_rd,
    input  logic                 i_flush,
    output logic [1:0]           o_issue,
    output logic [NREG-1:0]      o_busy_vec,
    output logic                 o_draining,
    output logic                 o_wb_err,
    output logic [CNT_W-1:0]     o_stall_cnt,
    output logic [CNT_W-1:0]     o_dual_cnt
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NREG-1:0]    r_busy;
    logic               r_wb_err;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_dual_cnt;

    logic [NREG-1:0]    w_wb_clr;
    logic [NREG-1:0]    w_eff_busy;
    logic [NREG-1:0]    w_set;
    logic [NREG-1:0]    w_busy_nxt;
    logic [1:0]         w_slot_ok;
    logic               w_pair_ok;
    logic               w_err_now;
    logic [1:0]         w_issue;

    // Writebacks landing this cycle unblock readers in the same cycle.
    always_comb begin
        w_wb_clr  = '0;
        w_err_now = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i_wb_valid[i]) begin
                w_wb_clr[i_wb_rd[i]] = 1'b1;
                if (!r_busy[i_wb_rd[i]]) w_err_now = 1'b1;
            end
        end
        if ((&i_wb_valid) && (i_wb_rd[0] == i_wb_rd[1]) && (i_wb_rd[0] != '0))
            w_err_now = 1'b1;
        w_eff_busy    = r_busy & ~w_wb_clr;
        w_eff_busy[0] = 1'b0;
    end

    always_comb begin
        w_slot_ok = '0;
        for (int s = 0; s < 2; s++) begin
            w_slot_ok[s] = !w_eff_busy[i_slot_rs1[s]] && !w_eff_busy[i_slot_rs2[s]] &&
                           !(i_slot_we[s] && (i_slot_rd[s] != '0) && w_eff_busy[i_slot_rd[s]]);
        end
        w_pair_ok = 1'b1;
        if (i_slot_we[0] && (i_slot_rd[0] != '0)) begin
            if ((i_slot_rs1[1] == i_slot_rd[0]) || (i_slot_rs2[1] == i_slot_rd[0]))
                w_pair_ok = 1'b0;
            if (i_slot_we[1] && (i_slot_rd[1] == i_slot_rd[0]))
                w_pair_ok = 1'b0;
        end
    end

    always_comb begin
        w_issue    = '0;
        w_issue[0] = !rst && (r_state == ST_RUN) && i_slot_valid[0] && i_issue_ready &&
                     !i_flush && w_slot_ok[0];
        w_issue[1] = w_issue[0] && i_slot_valid[1] && w_slot_ok[1] && w_pair_ok;
    end

    // Set after clear so a same-cycle reissue to a retiring register stays busy.
    always_comb begin
        w_set = '0;
        for (int s = 0; s < 2; s++) begin
            if (w_issue[s] && i_slot_we[s] && (i_slot_rd[s] != '0))
                w_set[i_slot_rd[s]] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_wb_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (i_flush) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_busy_nxt == '0) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_busy      <= '0;
            r_wb_err    <= 1'b0;
            r_stall_cnt <= '0;
            r_dual_cnt  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_busy   <= w_busy_nxt;
            r_wb_err <= r_wb_err | w_err_now;
            if (i_slot_valid[0] && !w_issue[0]) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (&w_issue)                       r_dual_cnt  <= r_dual_cnt + CNT_W'(1);
        end
    end

    assign o_issue     = w_issue;
    assign o_busy_vec  = r_busy;
    assign o_draining  = (r_state == ST_DRAIN);
    assign o_wb_err    = r_wb_err;
    assign o_stall_cnt = r_stall_cnt;
    assign o_dual_cnt  = r_dual_cnt;

endmodule
